// File: rtl/acs_metric_ctrl.sv
// Add-compare-select engine and METRICMEMORY sequencer for a K=9, 256-state Viterbi decoder.
// One trellis step takes 64 RUN cycles (4 ACS each) plus one FLUSH cycle for the last write.
module acs_metric_ctrl #(
   parameter int         WD_METR   = 8,
   parameter int         N_ACS     = 4,
   parameter int         WD_DIST   = 4,
   parameter logic [8:0] G0        = 9'o561,
   parameter logic [8:0] G1        = 9'o753,
   parameter int         INIT_BIAS = 64
) (
   input  logic                       Clock1,
   input  logic                       Reset,
   input  logic                       Active,
   input  logic                       StepStart,
   input  logic [WD_DIST-1:0]         BM00,
   input  logic [WD_DIST-1:0]         BM01,
   input  logic [WD_DIST-1:0]         BM10,
   input  logic [WD_DIST-1:0]         BM11,
   input  logic [WD_METR*2*N_ACS-1:0] MMPathMetric,
   output logic [4:0]                 MMReadAddress,
   output logic [5:0]                 MMWriteAddress,
   output logic                       MMBlockSelect,
   output logic [WD_METR*N_ACS-1:0]   MMMetric,
   output logic                       MMWriteEn,
   output logic [N_ACS-1:0]           SurvBits,
   output logic [5:0]                 SurvAddr,
   output logic                       SurvValid,
   output logic                       StepDone,
   output logic                       Busy,
   output logic [1:0]                 o_dbg_state
);

   // StepStart is taken only in IDLE with Active=1; MMWriteEn/SurvValid qualify
   // MMMetric/MMWriteAddress/SurvBits/SurvAddr for exactly the cycles they are high.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

   localparam logic [WD_METR-1:0] HALF = {1'b1, {(WD_METR-1){1'b0}}};
   localparam logic [WD_METR-1:0] BIAS = WD_METR'(INIT_BIAS);

   state_t                   r_state, w_state_nxt;
   logic [5:0]               r_cnt, w_cnt_nxt;
   logic [WD_METR*N_ACS-1:0] r_metric, w_new;
   logic [N_ACS-1:0]         r_surv, w_dec;
   logic [5:0]               r_wr_addr;
   logic                     r_wr_en, r_done, r_bsel, r_first, r_norm, r_msb_acc;
   logic                     w_any_msb, w_run;

   function automatic logic [1:0] f_label(input logic b, input logic [7:0] s);
      logic [8:0] v;
      v = {b, s};
      return {^(v & G0), ^(v & G1)};
   endfunction

   always_ff @(posedge Clock1 or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else if (Active) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (StepStart) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            w_cnt_nxt = r_cnt + 6'd1;
            if (r_cnt == 6'd63) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_run = (r_state == S_RUN);

   // Slot 2j+k of read word r is old state 8r+2j+k; ACS j builds new state 4r+j (+128 on phase 1).
   always_comb begin
      logic [7:0]         l_state;
      logic [WD_METR-1:0] l_raw;
      logic [WD_METR-1:0] l_old;
      logic [WD_DIST-1:0] l_bm;
      logic [WD_METR:0]   l_sum [2];
      logic [WD_METR:0]   l_win;
      w_new     = '0;
      w_dec     = '0;
      w_any_msb = 1'b0;
      l_state   = '0;
      l_raw     = '0;
      l_old     = '0;
      l_bm      = '0;
      l_sum[0]  = '0;
      l_sum[1]  = '0;
      l_win     = '0;
      for (int j = 0; j < N_ACS; j++) begin
         for (int k = 0; k < 2; k++) begin
            l_state = {r_cnt[5:1], 3'(2 * j + k)};
            l_raw   = MMPathMetric[(2 * j + k) * WD_METR +: WD_METR];
            if (r_first)     l_old = (l_state == 8'd0) ? '0 : BIAS;
            else if (r_norm) l_old = (l_raw >= HALF) ? (l_raw - HALF) : '0;
            else             l_old = l_raw;
            case (f_label(r_cnt[0], l_state))
               2'b00:   l_bm = BM00;
               2'b01:   l_bm = BM01;
               2'b10:   l_bm = BM10;
               default: l_bm = BM11;
            endcase
            l_sum[k] = {1'b0, l_old} + {{(WD_METR + 1 - WD_DIST){1'b0}}, l_bm};
         end
         w_dec[j] = (l_sum[1] < l_sum[0]);
         l_win    = w_dec[j] ? l_sum[1] : l_sum[0];
         w_new[j*WD_METR +: WD_METR] = l_win[WD_METR] ? '1 : l_win[WD_METR-1:0];
         w_any_msb = w_any_msb | w_new[j*WD_METR + WD_METR - 1];
      end
   end

   always_ff @(posedge Clock1 or negedge Reset) begin
      if (!Reset) begin
         r_metric  <= '0;
         r_surv    <= '0;
         r_wr_addr <= '0;
         r_wr_en   <= 1'b0;
         r_done    <= 1'b0;
         r_bsel    <= 1'b0;
         r_first   <= 1'b1;
         r_norm    <= 1'b0;
         r_msb_acc <= 1'b0;
      end else if (Active) begin
         r_wr_en <= w_run;
         r_done  <= (r_state == S_FLUSH);
         if (w_run) begin
            r_metric  <= w_new;
            r_surv    <= w_dec;
            r_wr_addr <= {r_cnt[0], r_cnt[5:1]};
            r_msb_acc <= r_msb_acc | w_any_msb;
         end
         if (r_state == S_FLUSH) begin
            r_bsel    <= ~r_bsel;
            r_first   <= 1'b0;
            r_norm    <= r_msb_acc;
            r_msb_acc <= 1'b0;
         end
      end
   end

   // Held registers are masked rather than cleared so a frozen write replays on resume.
   assign MMReadAddress  = r_cnt[5:1];
   assign MMWriteAddress = r_wr_addr;
   assign SurvAddr       = r_wr_addr;
   assign MMMetric       = r_metric;
   assign SurvBits       = r_surv;
   assign MMWriteEn      = r_wr_en & Active;
   assign SurvValid      = r_wr_en & Active;
   assign StepDone       = r_done & Active;
   assign MMBlockSelect  = r_bsel;
   assign Busy           = (r_state != S_IDLE);
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_acs_metric_ctrl.sv
// Bench for acs_metric_ctrl: ping-pong metric memory model, 256-state golden trellis model
// that queues the expected writes, and a write monitor that drains the queue.
`timescale 1ns/1ps
module tb_acs_metric_ctrl;
   localparam logic [8:0] TG0 = 9'o561;
   localparam logic [8:0] TG1 = 9'o753;

   logic        Clock1 = 1'b0;
   logic        Reset = 1'b0;
   logic        Active = 1'b0;
   logic        StepStart = 1'b0;
   logic [3:0]  BM00 = '0, BM01 = '0, BM10 = '0, BM11 = '0;
   logic [63:0] MMPathMetric;
   logic [4:0]  MMReadAddress;
   logic [5:0]  MMWriteAddress;
   logic        MMBlockSelect;
   logic [31:0] MMMetric;
   logic        MMWriteEn;
   logic [3:0]  SurvBits;
   logic [5:0]  SurvAddr;
   logic        SurvValid;
   logic        StepDone;
   logic        Busy;
   logic [1:0]  o_dbg_state;

   int total = 0;
   int bad = 0;
   int n_writes = 0;
   logic [41:0] exp_q[$];
   logic [31:0] cap_metric [64];
   logic [3:0]  cap_surv [64];

   logic [31:0] bank_a [64];
   logic [31:0] bank_b [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   int gold_old [256];
   bit m_first = 1'b1;
   bit m_norm = 1'b0;
   bit m_sel = 1'b0;

   acs_metric_ctrl dut (
      .Clock1(Clock1), .Reset(Reset), .Active(Active), .StepStart(StepStart),
      .BM00(BM00), .BM01(BM01), .BM10(BM10), .BM11(BM11),
      .MMPathMetric(MMPathMetric), .MMReadAddress(MMReadAddress),
      .MMWriteAddress(MMWriteAddress), .MMBlockSelect(MMBlockSelect),
      .MMMetric(MMMetric), .MMWriteEn(MMWriteEn), .SurvBits(SurvBits),
      .SurvAddr(SurvAddr), .SurvValid(SurvValid), .StepDone(StepDone),
      .Busy(Busy), .o_dbg_state(o_dbg_state)
   );

   always #5 Clock1 = ~Clock1;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout need=finish");
      $fatal(1);
   end

   assign MMPathMetric = MMBlockSelect ?
      {bank_a[{MMReadAddress, 1'b1}], bank_a[{MMReadAddress, 1'b0}]} :
      {bank_b[{MMReadAddress, 1'b1}], bank_b[{MMReadAddress, 1'b0}]};

   always @(posedge Clock1) begin
      if (MMWriteEn === 1'b1) begin
         if (MMBlockSelect) bank_b[MMWriteAddress] <= MMMetric;
         else               bank_a[MMWriteAddress] <= MMMetric;
      end
      if (pl_en) begin
         if (MMBlockSelect) bank_a[pl_addr] <= pl_data;
         else               bank_b[pl_addr] <= pl_data;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h need=%0h", name, got, want);
      end
   endtask

   always @(negedge Clock1) begin
      logic [41:0] e;
      if (MMWriteEn === 1'b1) begin
         n_writes++;
         cap_metric[MMWriteAddress] = MMMetric;
         cap_surv[MMWriteAddress]   = SurvBits;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write got addr=%0d data=%h need=none", MMWriteAddress, MMMetric);
         end else begin
            e = exp_q.pop_front();
            check("write_word", 64'({MMWriteAddress, MMMetric, SurvBits}), 64'(e));
            check("surv_addr_valid", 64'({SurvAddr, SurvValid, Active}), 64'({e[41:36], 2'b11}));
         end
      end
   end

   function automatic int parity9(input logic [8:0] v);
      int p;
      p = 0;
      for (int i = 0; i < 9; i++) p = p ^ int'(v[i]);
      return p;
   endfunction

   task automatic model_step(input logic [3:0] b00, input logic [3:0] b01,
                             input logic [3:0] b10, input logic [3:0] b11);
      int oldv [256];
      int newv [256];
      bit dec [256];
      int bm [4];
      bit any;
      bm[0] = int'(b00); bm[1] = int'(b01); bm[2] = int'(b10); bm[3] = int'(b11);
      for (int s = 0; s < 256; s++) begin
         if (m_first)     oldv[s] = (s == 0) ? 0 : 64;
         else if (m_norm) oldv[s] = (gold_old[s] >= 128) ? gold_old[s] - 128 : 0;
         else             oldv[s] = gold_old[s];
      end
      any = 1'b0;
      for (int n = 0; n < 256; n++) begin
         int sum [2];
         for (int k = 0; k < 2; k++) begin
            int p;
            logic [8:0] v;
            p = (n % 128) * 2 + k;
            v = 9'((n / 128) * 256 + p);
            sum[k] = oldv[p] + bm[parity9(v & TG0) * 2 + parity9(v & TG1)];
         end
         if (sum[1] < sum[0]) begin newv[n] = sum[1]; dec[n] = 1'b1; end
         else                 begin newv[n] = sum[0]; dec[n] = 1'b0; end
         if (newv[n] > 255) newv[n] = 255;
         if (newv[n] >= 128) any = 1'b1;
      end
      for (int c = 0; c < 64; c++) begin
         int w;
         logic [31:0] word;
         logic [3:0]  sb;
         w = (c % 2) * 32 + c / 2;
         for (int j = 0; j < 4; j++) begin
            word[j*8 +: 8] = 8'(newv[4 * w + j]);
            sb[j] = dec[4 * w + j];
         end
         exp_q.push_back({6'(w), word, sb});
      end
      for (int s = 0; s < 256; s++) gold_old[s] = newv[s];
      m_norm  = any;
      m_first = 1'b0;
      m_sel   = ~m_sel;
   endtask

   task automatic preload(input logic [5:0] addr, input logic [31:0] data);
      @(negedge Clock1);
      pl_en = 1'b1; pl_addr = addr; pl_data = data;
      @(negedge Clock1);
      pl_en = 1'b0;
      for (int j = 0; j < 4; j++) gold_old[4 * int'(addr) + j] = int'(data[j*8 +: 8]);
   endtask

   task automatic run_step(input logic [3:0] b00, input logic [3:0] b01,
                           input logic [3:0] b10, input logic [3:0] b11,
                           input int gap_c, input int abort_c, input int restart_c);
      int edges;
      int w0;
      bit done;
      bit aborted;
      model_step(b00, b01, b10, b11);
      w0 = n_writes;
      @(negedge Clock1);
      BM00 = b00; BM01 = b01; BM10 = b10; BM11 = b11;
      StepStart = 1'b1;
      edges = 0; done = 1'b0; aborted = 1'b0;
      while (!done && !aborted && edges < 200) begin
         @(posedge Clock1);
         edges++;
         @(negedge Clock1);
         StepStart = 1'b0;
         if (edges - 1 == gap_c) Active = 1'b0;
         if (gap_c >= 0 && edges - 1 == gap_c + 5) Active = 1'b1;
         if (edges - 1 == restart_c) StepStart = 1'b1;
         if (edges == 3) check("busy_in_run", 64'(Busy), 64'(1));
         if (edges - 1 == abort_c) begin
            Reset = 1'b0;
            #1;
            check("abort_outputs_zero", 64'({MMReadAddress, MMWriteAddress, MMBlockSelect, MMMetric,
                  MMWriteEn, SurvBits, SurvAddr, SurvValid, StepDone, Busy, o_dbg_state}), 64'(0));
            exp_q.delete();
            m_first = 1'b1; m_norm = 1'b0; m_sel = 1'b0;
            aborted = 1'b1;
            repeat (2) @(negedge Clock1);
            Reset = 1'b1;
         end else if (StepDone === 1'b1) begin
            done = 1'b1;
         end
      end
      if (!aborted) begin
         check("step_done_seen", 64'(done), 64'(1));
         check("step_latency", 64'(edges), 64'((gap_c >= 0) ? 71 : 66));
         check("writes_per_step", 64'(n_writes - w0), 64'(64));
         check("block_select", 64'(MMBlockSelect), 64'(m_sel));
         check("busy_after_done", 64'(Busy), 64'(0));
         check("queue_drained", 64'(exp_q.size()), 64'(0));
      end
   endtask

   initial begin
      Reset = 1'b0;
      repeat (3) @(negedge Clock1);
      check("reset_outputs_zero", 64'({MMReadAddress, MMWriteAddress, MMBlockSelect, MMMetric,
            MMWriteEn, SurvBits, SurvAddr, SurvValid, StepDone, Busy, o_dbg_state}), 64'(0));
      Reset = 1'b1;
      Active = 1'b1;
      @(negedge Clock1);

      run_step(4'd0, 4'd4, 4'd4, 4'd4, -1, -1, -1);
      check("s1_state0_metric", 64'(cap_metric[0][7:0]), 64'(0));
      check("s1_state0_dec", 64'(cap_surv[0][0]), 64'(0));

      // Old states 0..7 = 50,40,130,130,7,7,17,4 with every branch metric 3.
      preload(6'd0, {8'd130, 8'd130, 8'd40, 8'd50});
      preload(6'd1, {8'd4, 8'd17, 8'd7, 8'd7});
      run_step(4'd3, 4'd3, 4'd3, 4'd3, -1, -1, -1);
      check("s2_word0_tie_and_min", 64'(cap_metric[0]), 64'(32'h070A_852B));
      check("s2_surv0", 64'(cap_surv[0]), 64'(4'b1001));
      check("s2_word32", 64'(cap_metric[32]), 64'(32'h070A_852B));
      check("s2_surv32", 64'(cap_surv[32]), 64'(4'b1001));

      // Normalized: old 43 -> 0, 133 -> 5, so new state 0 = min(2, 7).
      run_step(4'd2, 4'd2, 4'd2, 4'd2, -1, -1, 40);
      check("s3_norm_state0", 64'(cap_metric[0][7:0]), 64'(2));
      check("s3_norm_dec0", 64'(cap_surv[0][0]), 64'(0));

      run_step(4'd1, 4'd5, 4'd9, 4'd13, 20, -1, -1);

      run_step(4'd2, 4'd7, 4'd0, 4'd11, -1, 30, -1);
      check("post_abort_bsel", 64'(MMBlockSelect), 64'(0));

      // After abort the first-step init applies again: state 0 = min(0+5, 64+2).
      run_step(4'd5, 4'd1, 4'd3, 4'd2, -1, -1, -1);
      check("s6_reinit_state0", 64'(cap_metric[0][7:0]), 64'(5));

      repeat (3) @(negedge Clock1);
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acs_metric_ctrl.md
Name: acs_metric_ctrl

Overview:
- Add-compare-select engine and sequencer for the Viterbi decoder. Sits downstream of the branch metric unit and wraps METRICMEMORY.
- Generates MMReadAddress, MMWriteAddress and MMBlockSelect for METRICMEMORY. Consumes MMPathMetric, returns new metrics on MMMetric.
- Streams survivor decision bits to the trace-back stage.
- Trellis: K=9, 256 states, 4 ACS per cycle, 64 cycles per trellis step.

Parameters:
- WD_METR, 8, path metric width (matches `WD_METR).
- N_ACS, 4, ACS units per cycle (matches `N_ACS).
- WD_DIST, 4, branch metric width.
- G0, 9'o561, generator polynomial 0.
- G1, 9'o753, generator polynomial 1.
- INIT_BIAS, 64, starting metric for all states except state 0.

Ports:
- Clock1  in  1  system clock, all logic on posedge.
- Reset  in  1  asynchronous active-low reset.
- Active  in  1  global enable; when 0 the block holds all state and drives no writes.
- StepStart  in  1  one-cycle pulse from the BMU: branch metrics valid for one trellis step.
- BM00/BM01/BM10/BM11  in  WD_DIST each  branch metrics for symbol pairs 00/01/10/11; held stable until StepDone.
- MMPathMetric  in  WD_METR*2*N_ACS  8 old metrics from METRICMEMORY; combinational response to MMReadAddress.
- MMReadAddress  out  5  old-metric word address.
- MMWriteAddress  out  6  new-metric word address.
- MMBlockSelect  out  1  0 = write A / read B, 1 = write B / read A.
- MMMetric  out  WD_METR*N_ACS  4 new metrics.
- MMWriteEn  out  1  MMMetric/MMWriteAddress valid this cycle.
- SurvBits  out  N_ACS  decision bits; 1 = odd predecessor won.
- SurvAddr  out  6  survivor word address (equals MMWriteAddress).
- SurvValid  out  1  SurvBits valid.
- StepDone  out  1  one-cycle pulse after the 64th write of a step.
- Busy  out  1  high while a step is in progress.

Behaviour:
- Reset (Reset=0): every output 0. FSM=IDLE, cycle counter=0, norm flag=0, first-step flag=1. Active-low reset, asynchronous assert, synchronous deassert to Clock1.
- FSM states:
  - IDLE: wait for StepStart with Active=1, then go to RUN. Busy=0.
  - RUN: counter c runs 0..63. MMReadAddress=c[5:1], phase=c[0].
    - Word r holds old states 8r..8r+7. Butterflies use old pairs (2i, 2i+1), i = 4r..4r+3.
    - phase 0 → new states i (input bit 0). Write address {1'b0, r}.
    - phase 1 → new states i+128 (input bit 1). Write address {1'b1, r}.
    - At c=63, go to FLUSH.
  - FLUSH: one cycle for the final registered write. Then toggle MMBlockSelect, pulse StepDone, clear first-step flag, return to IDLE.
- StepStart in FLUSH: ignored (same cycle). StepStart in RUN: ignored. The BMU must wait for StepDone.
- ACS datapath: pm_s + BM[label(s,b)] for both predecessors. label = {parity({b,s}&G0), parity({b,s}&G1)}.
  - Compare: unsigned, ties choose the even predecessor (decision 0).
  - Sum width WD_METR+1, saturate to 2^WD_METR-1.
- Latency: ACS combinational from MMPathMetric. MMMetric, MMWriteAddress, MMWriteEn, SurvBits, SurvAddr and SurvValid are registered, so they appear 1 cycle after the read address that produced them.
- Per step: 64 writes (MMWriteEn high cycles RUN c=1..63 plus FLUSH).
- Normalization: if any new metric in a step has MSB set, set the norm flag for the next step. With the flag set, subtract 2^(WD_METR-1) from every old metric before the add, floored at 0. The flag is re-evaluated every step.
- First step after reset: ignore MMPathMetric. Old metric = 0 for state 0, INIT_BIAS for all others.
- Active=0 mid-step: freeze counter, FSM and outputs. MMWriteEn and SurvValid forced 0 while frozen. Resume exactly where stopped.
- Reset mid-step: abort immediately. MMBlockSelect returns to 0, first-step flag set.

Test Plan:
- Reset, then StepStart with BM00=0, BM01=BM10=BM11=4 → first write: addr 0, new state0 = 0, SurvBits[0]=0. StepDone 66 cycles after StepStart (IDLE→RUN 1 cycle, 64 RUN, 1 FLUSH). MMBlockSelect 0→1.
- Full step with behavioural memory model: MMWriteAddress sequence 0,32,1,33,...,31,63. Metric contents match a 256-state golden model; two consecutive steps are checked through the ping-pong.
- Tie case: both predecessor sums 10 → result 10, decision bit 0. Predecessor sums 20 vs 7 → 7, bit 1.
- Normalization: preload a metric of 130 → step produces a result with MSB set. Next step: every old metric reduced by 128, results equal the golden model.
- Active dropped for 5 cycles at c=20 → no writes during the gap. Addresses resume at write 10, 64 total writes, StepDone delayed by 5 cycles.
- Reset asserted at c=30 → all outputs 0 same cycle. The next step restarts at first-step init and MMBlockSelect=0.
